muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal values 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(XLEN)+1, giving the iteration counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the request on opcode and operands is valid.
REQ-006 Port in_ready, output, 1 bit: the unit can accept a request this cycle.
REQ-007 Port opcode, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 Port operand_1, input, XLEN bits: multiplicand or dividend.
REQ-009 Port operand_2, input, XLEN bits: multiplier or divisor.
REQ-010 Port kill, input, 1 bit: abort the operation in flight.
REQ-011 Port out_valid, output, 1 bit: answer is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the answer.
REQ-013 Port answer, output, XLEN bits: the result.
REQ-014 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 Request acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL equal (state==IDLE).
REQ-016 Operands and opcode SHALL be registered at acceptance; input changes afterwards SHALL not affect the result.
REQ-017 FSM states SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on accept, CALC->FIX when the counter reaches XLEN, FIX->DONE unconditionally, DONE->IDLE when out_ready=1.
REQ-018 CALC SHALL run exactly XLEN cycles: one shift-add step (multiply) or one restoring subtract-shift step (divide) per cycle, on magnitudes.
REQ-019 FIX SHALL apply the sign correction: negate the product if exactly one signed operand is negative; quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
REQ-020 Normal latency: out_valid SHALL be high in the cycle after the (XLEN+2)th rising edge following acceptance (34 edges for XLEN=32).
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN] with signed x signed, signed x unsigned and unsigned x unsigned interpretation respectively.
REQ-022 Divide by zero SHALL bypass CALC and go IDLE->DONE in one edge: DIV/DIVU answer all ones, REM/REMU answer operand_1.
REQ-023 Signed overflow (DIV/REM, op1 = most negative value, op2 = -1) SHALL bypass CALC and go IDLE->DONE in one edge: DIV answer op1, REM answer 0.
REQ-024 answer and out_valid SHALL stay stable in DONE until out_ready=1; out_valid SHALL deassert on the edge that sees out_ready=1.
REQ-025 No new request SHALL be accepted on the edge that completes the DONE handshake; the earliest next acceptance SHALL be the following edge.
REQ-026 kill=1 in CALC or FIX SHALL force IDLE on the next edge, produce no out_valid, and leave answer unchanged; kill SHALL be ignored in IDLE and DONE.
REQ-027 If kill and in_valid are both high in IDLE, the request SHALL be accepted.

Reset
REQ-028 On a rising edge with rst=1, the FSM SHALL go to IDLE, the counter SHALL be 0, and answer SHALL be 0.
REQ-029 During reset, out_valid and busy SHALL be 0 and in_ready SHALL be 1 in the cycle after the reset edge.
REQ-030 rst SHALL take priority over kill and over any handshake, including when asserted mid-CALC.

Configuration
REQ-031 Macro MULDIV_DIV_EN SHALL control whether the divider is built.
REQ-032 With MULDIV_DIV_EN defined, all eight opcodes SHALL be supported as specified above.
REQ-033 Without MULDIV_DIV_EN, opcodes 4..7 SHALL go IDLE->DONE in one edge with answer 0, no divide datapath SHALL be synthesised, and multiply behaviour SHALL be unchanged.

Structure
REQ-034 Package muldiv_pkg SHALL hold the opcode enum, the FSM state enum and the opcode decode helpers is_div, is_signed_op1 and is_signed_op2.
REQ-035 Sub-module muldiv_div_step SHALL implement one combinational restoring-division step (remainder, quotient, divisor in; remainder, quotient out).
REQ-036 The multiply step, counter and FSM SHALL reside in muldiv_unit.

Verification
REQ-037 The bench SHALL drive MUL with 0xFFFFFFFF x 0x00000002 (XLEN=32) and check answer 0xFFFFFFFE with out_valid after 34 edges.
REQ-038 The bench SHALL drive MULH, MULHSU and MULHU with 0x80000000 x 0xFFFFFFFF and check answers 0x00000000, 0x80000000 and 0x7FFFFFFF.
REQ-039 The bench SHALL drive DIV and REM with -7 and 2 and check answers 0xFFFFFFFD and 0xFFFFFFFF; DIVU with 7 and 0 SHALL return 0xFFFFFFFF after 1 edge.
REQ-040 The bench SHALL drive DIV and REM with 0x80000000 and 0xFFFFFFFF and check answers 0x80000000 and 0, each after 1 edge.
REQ-041 The bench SHALL hold out_ready=0 for 10 cycles and check answer stable, in_ready=0, and a new request accepted one edge after the out_ready handshake.
REQ-042 The bench SHALL assert kill at CALC cycle 5 and check IDLE next edge with no out_valid, then assert rst at CALC cycle 5 and check answer=0, in_ready=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - opcode/state enums and opcode decode helpers for muldiv_unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(opcode_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_op1(opcode_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_op2(opcode_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-division step on magnitudes
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // One extra bit keeps the borrow separate from a legitimately large shifted remainder
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};

  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN+1]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider
// Divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      opcode,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] answer,
  output logic            busy
);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  opcode_e           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q;

  opcode_e           op_in;
  logic              accept, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              bypass;
  logic [XLEN-1:0]   bypass_ans;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_ans;

  assign op_in     = opcode_e'(opcode);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid & in_ready;

  assign s1   = is_signed_op1(op_in) & operand_1[XLEN-1];
  assign s2   = is_signed_op2(op_in) & operand_2[XLEN-1];
  assign mag1 = s1 ? -operand_1 : operand_1;
  assign mag2 = s2 ? -operand_2 : operand_2;

  // hi/lo is the product accumulator for multiply and remainder/quotient for divide
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic [XLEN-1:0] div_hi, div_lo, div_sel;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (hi_q),
    .quo_in  (lo_q),
    .divisor (opnd_q),
    .rem_out (div_hi),
    .quo_out (div_lo)
  );

  always_comb begin
    bypass     = 1'b0;
    bypass_ans = '0;
    if (is_div(op_in)) begin
      if (operand_2 == '0) begin
        bypass     = 1'b1;
        bypass_ans = (op_in == OP_REM || op_in == OP_REMU) ? operand_1 : '1;
      end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                   operand_1 == MIN_NEG && operand_2 == '1) begin
        bypass     = 1'b1;
        bypass_ans = (op_in == OP_REM) ? '0 : operand_1;
      end
    end
  end

  assign step_hi = is_div(op_q) ? div_hi : mul_sum[XLEN:1];
  assign step_lo = is_div(op_q) ? div_lo : {mul_sum[0], lo_q[XLEN-1:1]};
  assign div_sel = (op_q == OP_REM || op_q == OP_REMU) ? hi_q : lo_q;

  always_comb begin
    fix_ans = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    if (is_div(op_q)) fix_ans = neg_q ? -div_sel : div_sel;
  end
`else
  assign bypass     = is_div(op_in);
  assign bypass_ans = '0;
  assign step_hi    = mul_sum[XLEN:1];
  assign step_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
  assign fix_ans    = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = bypass ? S_DONE : S_CALC;
      S_CALC: begin
        if (kill)                               state_nxt = S_IDLE;
        else if (cnt == CNT_W'(XLEN - 1))       state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = kill ? S_IDLE : S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      answer <= '0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          op_q   <= op_in;
          cnt    <= '0;
          hi_q   <= '0;
          // Remainder takes the dividend's sign; product and quotient take the XOR
          neg_q  <= (op_in == OP_REM) ? s1 : (s1 ^ s2);
          lo_q   <= is_div(op_in) ? mag1 : mag2;
          opnd_q <= is_div(op_in) ? mag2 : mag1;
          if (bypass) answer <= bypass_ans;
        end
        S_CALC: if (!kill) begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt + 1'b1;
        end
        S_FIX: if (!kill) answer <= fix_ans;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (MULDIV_DIV_EN aware)
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] answer;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .answer    (answer),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the inputs
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op; operand_1 = a; operand_2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom; opcode = 3'($urandom);
  endtask

  // Edge count includes the acceptance edge
  task automatic wait_valid(input string tag, input int exp_edges, input logic [31:0] exp_ans);
    int edges = 1;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " answer"}, 64'(answer), 64'(exp_ans));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " release"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_edges, input logic [31:0] exp_ans);
    issue(op, a, b);
    wait_valid(tag, exp_edges, exp_ans);
    release_out(tag);
  endtask

  initial begin
    int hits;
    tick(); tick();
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset answer", 64'(answer), 64'd0);

    run_op("mul ffffffff*2", 3'd0, 32'hFFFF_FFFF, 32'h2, 34, 32'hFFFF_FFFE);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h7FFF_FFFF);
    run_op("mul neg*pos", 3'd0, 32'hFFFF_FFFD, 32'h5, 34, 32'hFFFF_FFF1);

`ifdef MULDIV_DIV_EN
    run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFD);
    run_op("rem -7%2", 3'd6, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFF);
    run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 34, 32'd14);
    run_op("remu 100%7", 3'd7, 32'd100, 32'd7, 34, 32'd2);
    run_op("divu by zero", 3'd5, 32'd7, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu by zero", 3'd7, 32'd7, 32'd0, 1, 32'd7);
    run_op("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
`else
    run_op("div disabled", 3'd4, 32'hFFFF_FFF9, 32'h2, 1, 32'h0);
    run_op("remu disabled", 3'd7, 32'd100, 32'd7, 1, 32'h0);
`endif

    // Backpressure: a pending request must wait until one edge after the handshake
    issue(3'd0, 32'd3, 32'd5);
    wait_valid("bp", 34, 32'd15);
    opcode = 3'd0; operand_1 = 32'd6; operand_2 = 32'd7; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp hold answer", 64'(answer), 64'd15);
      check("bp hold in_ready", 64'(in_ready), 64'd0);
      check("bp hold out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp handshake out_valid", 64'(out_valid), 64'd0);
    check("bp handshake not accepted", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp next accepted", 64'(busy), 64'd1);
    wait_valid("bp next", 34, 32'd42);
    release_out("bp next");

    // kill with in_valid in IDLE still accepts; kill in DONE is ignored
    kill = 1'b1;
    issue(3'd0, 32'd4, 32'd5);
    kill = 1'b0;
    check("kill idle accepted", 64'(busy), 64'd1);
    wait_valid("kill idle", 34, 32'd20);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill done ignored", 64'(out_valid), 64'd1);
    release_out("kill done");

    // kill at CALC cycle 5
    issue(3'd0, 32'd9, 32'd9);
    repeat (4) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill calc idle", 64'(in_ready), 64'd1);
    check("kill calc busy", 64'(busy), 64'd0);
    check("kill calc answer kept", 64'(answer), 64'd20);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) hits++;
    end
    check("kill calc no out_valid", 64'(hits), 64'd0);

    // rst at CALC cycle 5 wins over a simultaneous kill
    issue(3'd0, 32'd9, 32'd9);
    repeat (4) tick();
    rst = 1'b1; kill = 1'b1;
    tick();
    rst = 1'b0; kill = 1'b0;
    check("rst calc answer", 64'(answer), 64'd0);
    check("rst calc in_ready", 64'(in_ready), 64'd1);
    check("rst calc out_valid", 64'(out_valid), 64'd0);
    check("rst calc busy", 64'(busy), 64'd0);

    run_op("mul after rst", 3'd0, 32'h1234, 32'h10, 34, 32'h12340);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
